// File: rtl/vga_cell_scanner_pkg.sv
// Shared constants and types for the VGA cell scanner: 640x480@60 timing, cell grid
// geometry, blank colour and the per-pixel flag bundle carried down the pipeline.
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int CELL_SHIFT = 4;
    localparam int GRID_W     = H_ACTIVE >> CELL_SHIFT;
    localparam int GRID_H     = V_ACTIVE >> CELL_SHIFT;
    localparam int ADDR_W     = 11;
    localparam int CNT_W      = 10;

    localparam logic       SYNC_POL = 1'b0;
    localparam logic [3:0] BLANK_ID = 4'hF;

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic first;
    } pix_flags_t;

    localparam pix_flags_t FLAGS_IDLE = '{active: 1'b0, hsync: ~SYNC_POL, vsync: ~SYNC_POL, first: 1'b0};

    // Sync pulse occupies [start, start+len) of the counter range.
    function automatic logic sync_level(input logic [CNT_W-1:0] cnt, input int start, input int len);
        return (cnt >= CNT_W'(start) && cnt < CNT_W'(start + len)) ? SYNC_POL : ~SYNC_POL;
    endfunction
endpackage

// File: rtl/vga_cell_scanner_if.sv
// Cell-memory read port plus the delay-matched video stream towards ColorCvt.
interface vga_cell_scanner_if;
    import vga_pkg::*;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_rdata;
    logic [3:0]        color_id;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic              frame_start;

    modport master (
        output mem_en, mem_addr, color_id, hsync, vsync, de, frame_start,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_addr, color_id, hsync, vsync, de, frame_start,
        output mem_rdata
    );
endinterface

// File: rtl/vga_cell_scanner_timing_counter.sv
// Horizontal/vertical raster counters advancing once per pix_ce, with the raw
// (undelayed) active, sync and first-pixel flags decoded from the counter state.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output pix_flags_t       flags
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        flags.active = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
        flags.hsync  = sync_level(h_cnt, H_ACTIVE + H_FP, H_SYNC);
        flags.vsync  = sync_level(v_cnt, V_ACTIVE + V_FP, V_SYNC);
        flags.first  = (h_cnt == '0) && (v_cnt == '0);
    end
endmodule

// File: rtl/vga_cell_scanner.sv
// Raster scan -> cell address -> colour id fetch, with sync/DE delayed through the same
// two pix_ce stages as the memory read so everything reaches ColorCvt aligned.
module vga_cell_scanner
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int H_FP       = vga_pkg::H_FP,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BP       = vga_pkg::H_BP,
    parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int V_FP       = vga_pkg::V_FP,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BP       = vga_pkg::V_BP,
    parameter int CELL_SHIFT = vga_pkg::CELL_SHIFT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_ce,
    vga_cell_scanner_if.master  bus
);
    localparam int GRID_W = H_ACTIVE >> CELL_SHIFT;
    localparam int GRID_H = V_ACTIVE >> CELL_SHIFT;

    if (GRID_W * GRID_H > (1 << ADDR_W)) begin : g_addr_chk
        $error("vga_cell_scanner: cell grid does not fit in ADDR_W");
    end

    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic [ADDR_W-1:0] cell_addr;
    pix_flags_t        flags;
    pix_flags_t        s1;

    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .pix_ce (pix_ce),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .flags  (flags)
    );

    always_comb begin
        cell_addr = ADDR_W'(v_cnt >> CELL_SHIFT) * ADDR_W'(GRID_W) + ADDR_W'(h_cnt >> CELL_SHIFT);
    end

    // Read is issued in the same pix_ce cycle that stage 1 captures the flags,
    // so mem_rdata lines up with s1 on the next pulse.
    assign bus.mem_en   = flags.active & pix_ce & ~rst;
    assign bus.mem_addr = flags.active ? cell_addr : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1              <= FLAGS_IDLE;
            bus.color_id    <= BLANK_ID;
            bus.hsync       <= ~SYNC_POL;
            bus.vsync       <= ~SYNC_POL;
            bus.de          <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            // Strobe, not state: drops again on the first clk without pix_ce.
            bus.frame_start <= pix_ce & s1.first;
            if (pix_ce) begin
                s1           <= flags;
                bus.color_id <= s1.active ? bus.mem_rdata : BLANK_ID;
                bus.hsync    <= s1.hsync;
                bus.vsync    <= s1.vsync;
                bus.de       <= s1.active;
            end
        end
    end
endmodule

// File: tb/tb_vga_cell_scanner.sv
// Bench for vga_cell_scanner on a shrunken raster (same rules, fewer pixels) so several
// full frames fit in a short run; expected stream comes from pixel-index arithmetic.
module tb_vga_cell_scanner;
    import vga_pkg::*;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 48, VF = 2, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int GW = HA / 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_ce = 1'b0;
    int total = 0;
    int bad = 0;

    vga_cell_scanner_if bus();

    vga_cell_scanner #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .CELL_SHIFT (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pix_ce (pix_ce),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Cell memory: synchronous read, content of each cell is its address low nibble.
    always @(posedge clk) if (bus.mem_en) bus.mem_rdata <= bus.mem_addr[3:0];

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- reference model (pixel-index arithmetic) ----------------
    function automatic bit px_active(input int p);
        int h = p % HT;
        int v = (p / HT) % VT;
        return (h < HA) && (v < VA);
    endfunction

    function automatic logic [ADDR_W-1:0] exp_addr(input int p);
        int h = p % HT;
        int v = (p / HT) % VT;
        if (px_active(p)) return ADDR_W'((v / 16) * GW + h / 16);
        return '0;
    endfunction

    // Outputs expected right after the pulse with 0-based index k since reset release.
    function automatic logic [7:0] exp_out(input int k);
        int p, h, v;
        logic [3:0] cid;
        logic hs, vs, d, fs;
        if (k == 0) return {4'hF, 1'b1, 1'b1, 1'b0, 1'b0};
        p  = k - 1;
        h  = p % HT;
        v  = (p / HT) % VT;
        d  = px_active(p);
        cid = d ? exp_addr(p) [3:0] : 4'hF;
        hs = !(h >= HA + HF && h < HA + HF + HS);
        vs = !(v >= VA + VF && v < VA + VF + VS);
        fs = (h == 0) && (v == 0);
        return {cid, hs, vs, d, fs};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic do_reset();
        rst = 1'b1;
        pix_ce = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One pix_ce pulse followed by gap-1 idle clks; samples read port and outputs.
    task automatic drive_pulse(input int gap, output logic m_en, output logic [ADDR_W-1:0] m_addr,
                               output logic [7:0] outs, output int fs_extra);
        pix_ce = 1'b1;
        #1;
        m_en   = bus.mem_en;
        m_addr = bus.mem_addr;
        @(negedge clk);
        pix_ce = 1'b0;
        outs = {bus.color_id, bus.hsync, bus.vsync, bus.de, bus.frame_start};
        fs_extra = 0;
        repeat (gap - 1) begin
            @(negedge clk);
            if (bus.frame_start) fs_extra++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] o;
        rst = 1'b1;
        pix_ce = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            pix_ce = (c % 2 == 0);
            #1;
            total++;
            if (bus.mem_en !== 1'b0) begin
                bad++;
                $display("FAIL reset_mem_en cyc %0d: got %b want 0", c, bus.mem_en);
            end
            @(negedge clk);
            o = {bus.color_id, bus.hsync, bus.vsync, bus.de, bus.frame_start};
            total++;
            if (o !== {4'hF, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL reset_outputs cyc %0d: got cid=%h hs=%b vs=%b de=%b fs=%b want cid=f hs=1 vs=1 de=0 fs=0",
                         c, o[7:4], o[3], o[2], o[1], o[0]);
            end
        end
        pix_ce = 1'b0;
    endtask

    task automatic test_scan(input string tag, input int n, input bit irregular);
        logic m_en;
        logic [ADDR_W-1:0] m_addr;
        logic [7:0] o, e;
        int fs_extra, gap;
        int de_cnt = 0, hs_low = 0, vs_low = 0, fs_seen = 0, fs_last = -1;
        do_reset();
        for (int i = 0; i < n; i++) begin
            gap = irregular ? int'($urandom_range(8, 2)) : 4;
            drive_pulse(gap, m_en, m_addr, o, fs_extra);
            total++;
            if (m_en !== px_active(i) || m_addr !== exp_addr(i)) begin
                bad++;
                $display("FAIL %s_mem pulse %0d: got en=%b addr=%0d want en=%b addr=%0d",
                         tag, i, m_en, m_addr, px_active(i), exp_addr(i));
            end
            e = exp_out(i);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL %s_out pulse %0d: got cid=%h hs=%b vs=%b de=%b fs=%b want cid=%h hs=%b vs=%b de=%b fs=%b",
                         tag, i, o[7:4], o[3], o[2], o[1], o[0], e[7:4], e[3], e[2], e[1], e[0]);
            end
            total++;
            if (fs_extra != 0) begin
                bad++;
                $display("FAIL %s_fs_width pulse %0d: frame_start high %0d extra clks, want 0", tag, i, fs_extra);
            end
            if (i >= 1 && i - 1 < FRAME) begin
                if (o[1]) de_cnt++;
                if (i - 1 < HT && !o[3]) hs_low++;
                if ((i - 1) % HT == 0 && !o[2]) vs_low++;
            end
            if (o[0]) begin
                if (fs_last >= 0) begin
                    total++;
                    if (i - fs_last != FRAME) begin
                        bad++;
                        $display("FAIL %s_fs_spacing: got %0d pulses want %0d", tag, i - fs_last, FRAME);
                    end
                end
                fs_last = i;
                fs_seen++;
            end
        end
        total++;
        if (de_cnt != HA * VA) begin
            bad++;
            $display("FAIL %s_de_count: got %0d want %0d", tag, de_cnt, HA * VA);
        end
        total++;
        if (hs_low != HS) begin
            bad++;
            $display("FAIL %s_hsync_low: got %0d want %0d", tag, hs_low, HS);
        end
        total++;
        if (vs_low != VS) begin
            bad++;
            $display("FAIL %s_vsync_lines: got %0d want %0d", tag, vs_low, VS);
        end
        total++;
        if (fs_seen != (n - 2) / FRAME + 1) begin
            bad++;
            $display("FAIL %s_fs_count: got %0d want %0d", tag, fs_seen, (n - 2) / FRAME + 1);
        end
    endtask

    task automatic test_cell_addr();
        logic m_en;
        logic [ADDR_W-1:0] m_addr;
        logic [7:0] o;
        int fs_extra;
        int target = 33 * HT + 17;
        do_reset();
        for (int i = 0; i < target; i++) drive_pulse(2, m_en, m_addr, o, fs_extra);
        drive_pulse(2, m_en, m_addr, o, fs_extra);
        total++;
        if (m_en !== 1'b1 || m_addr !== ADDR_W'(2 * GW + 1)) begin
            bad++;
            $display("FAIL cell_addr_17_33: got en=%b addr=%0d want en=1 addr=%0d", m_en, m_addr, 2 * GW + 1);
        end
        drive_pulse(2, m_en, m_addr, o, fs_extra);
        total++;
        if (o[7:4] !== 4'(2 * GW + 1) || o[1] !== 1'b1) begin
            bad++;
            $display("FAIL cell_color_17_33: got cid=%h de=%b want cid=%h de=1", o[7:4], o[1], 4'(2 * GW + 1));
        end
    endtask

    task automatic test_mid_reset();
        logic m_en;
        logic [ADDR_W-1:0] m_addr;
        logic [7:0] o;
        int fs_extra;
        do_reset();
        for (int i = 0; i < 20 * HT + 30; i++) drive_pulse(2, m_en, m_addr, o, fs_extra);
        rst = 1'b1;
        pix_ce = 1'b0;
        @(negedge clk);
        o = {bus.color_id, bus.hsync, bus.vsync, bus.de, bus.frame_start};
        total++;
        if (o !== {4'hF, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midreset_outputs: got cid=%h hs=%b vs=%b de=%b fs=%b want cid=f hs=1 vs=1 de=0 fs=0",
                     o[7:4], o[3], o[2], o[1], o[0]);
        end
        pix_ce = 1'b1;
        #1;
        total++;
        if (bus.mem_en !== 1'b0) begin
            bad++;
            $display("FAIL midreset_rst_wins_mem: got mem_en=%b want 0", bus.mem_en);
        end
        @(negedge clk);
        o = {bus.color_id, bus.hsync, bus.vsync, bus.de, bus.frame_start};
        total++;
        if (o !== {4'hF, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midreset_rst_wins_out: got cid=%h de=%b fs=%b want cid=f de=0 fs=0", o[7:4], o[1], o[0]);
        end
        pix_ce = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        drive_pulse(2, m_en, m_addr, o, fs_extra);
        total++;
        if (m_en !== 1'b1 || m_addr !== '0 || o[0] !== 1'b0 || o[1] !== 1'b0) begin
            bad++;
            $display("FAIL midreset_pulse0: got en=%b addr=%0d fs=%b de=%b want en=1 addr=0 fs=0 de=0",
                     m_en, m_addr, o[0], o[1]);
        end
        drive_pulse(2, m_en, m_addr, o, fs_extra);
        total++;
        if (o[0] !== 1'b1 || o[1] !== 1'b1 || o[7:4] !== 4'h0 || fs_extra != 0) begin
            bad++;
            $display("FAIL midreset_first_frame: got fs=%b de=%b cid=%h extra=%0d want fs=1 de=1 cid=0 extra=0",
                     o[0], o[1], o[7:4], fs_extra);
        end
    endtask

    initial begin
        test_reset();
        test_scan("regular", 2 * FRAME + 2, 1'b0);
        test_cell_addr();
        test_mid_reset();
        test_scan("irregular", FRAME + 2, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
